mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Fetch/data request ports plus MMU strobes shared by mem_arbiter and its clients.
// slave modport faces the arbiter; master modport faces the requesters and MMU model.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] rdata;
  logic        grant_mem;
  logic        mmu_read;
  logic        mmu_write;
  logic        mmu_bytemode;
  logic [31:0] mmu_addr;
  logic [31:0] mmu_wdata;
  logic [31:0] mmu_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, mmu_rdata,
    output if_ack, mem_ack, rdata, grant_mem,
    output mmu_read, mmu_write, mmu_bytemode, mmu_addr, mmu_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, mmu_rdata,
    input  if_ack, mem_ack, rdata, grant_mem,
    input  mmu_read, mmu_write, mmu_bytemode, mmu_addr, mmu_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single wait-stated SRAM/MMU port; IDLE -> ACCESS -> ACK.
// Ack arrives WAIT_CYCLES+2 cycles after grant; optional fetch anti-starvation via ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        grant_mem_q;
  logic        if_ack_q;
  logic        mem_ack_q;
  logic [31:0] rdata_q;
  logic        mmu_read_q;
  logic        mmu_write_q;
  logic        mmu_byte_q;
  logic [31:0] mmu_addr_q;
  logic [31:0] mmu_wdata_q;

  logic        pick_mem;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic        we_d;
  logic        byte_d;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;
  // Once enough data grants have gone by with a fetch waiting, a contested grant goes to fetch.
  assign pick_mem = bus.mem_req && !(bus.if_req && (starve_q >= 4'(STARVE_LIMIT)));
`else
  assign pick_mem = bus.mem_req;
`endif

  always_comb begin
    addr_d  = bus.if_addr;
    wdata_d = 32'd0;
    we_d    = 1'b0;
    byte_d  = 1'b0;
    if (pick_mem) begin
      addr_d  = bus.mem_addr;
      wdata_d = bus.mem_wdata;
      we_d    = bus.mem_we;
      byte_d  = bus.mem_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      grant_mem_q <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      rdata_q     <= 32'd0;
      mmu_read_q  <= 1'b0;
      mmu_write_q <= 1'b0;
      mmu_byte_q  <= 1'b0;
      mmu_addr_q  <= 32'd0;
      mmu_wdata_q <= 32'd0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.mem_req) begin
            state_q     <= ACCESS;
            cnt_q       <= 3'(WAIT_CYCLES);
            grant_mem_q <= pick_mem;
            mmu_read_q  <= !we_d;
            mmu_write_q <= we_d;
            mmu_byte_q  <= byte_d;
            mmu_addr_q  <= addr_d;
            mmu_wdata_q <= wdata_d;
`ifdef ARB_STARVE_GUARD_EN
            if (!pick_mem || !bus.if_req) begin
              starve_q <= 4'd0;
            end else if (starve_q != 4'hF) begin
              starve_q <= starve_q + 4'd1;
            end
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == 3'd0) begin
            state_q     <= ACK;
            rdata_q     <= mmu_write_q ? 32'd0 : bus.mmu_rdata;
            if_ack_q    <= !grant_mem_q;
            mem_ack_q   <= grant_mem_q;
            mmu_read_q  <= 1'b0;
            mmu_write_q <= 1'b0;
            mmu_byte_q  <= 1'b0;
            mmu_addr_q  <= 32'd0;
            mmu_wdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ACK: begin
          // Requests are not sampled here, so a requester still high during its ack is not re-granted.
          state_q     <= IDLE;
          if_ack_q    <= 1'b0;
          mem_ack_q   <= 1'b0;
          grant_mem_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_ack       = if_ack_q;
  assign bus.mem_ack      = mem_ack_q;
  assign bus.rdata        = rdata_q;
  assign bus.grant_mem    = grant_mem_q;
  assign bus.mmu_read     = mmu_read_q;
  assign bus.mmu_write    = mmu_write_q;
  assign bus.mmu_bytemode = mmu_byte_q;
  assign bus.mmu_addr     = mmu_addr_q;
  assign bus.mmu_wdata    = mmu_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT_CYCLES=2, STARVE_LIMIT=4); inputs change 1ns after each rising edge.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_byte  = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mmu_rdata = 32'd0;
  endtask

  int          acks[$];
  logic [31:0] exp_src;

  initial begin
    idle_inputs();
    bus.mmu_rdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    step();
    step();
    check_val("rst_if_ack",    bus.if_ack,    0);
    check_val("rst_mem_ack",   bus.mem_ack,   0);
    check_val("rst_rdata",     bus.rdata,     0);
    check_val("rst_grant_mem", bus.grant_mem, 0);
    check_val("rst_mmu_read",  bus.mmu_read,  0);
    check_val("rst_mmu_write", bus.mmu_write, 0);
    check_val("rst_mmu_addr",  bus.mmu_addr,  0);
    rst = 1'b0;

    // Single fetch: grant at edge 0, ACCESS in cycles 1-3, ack in cycle 4
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h8000_0000;
    step();
    check_val("f_c1_read", bus.mmu_read, 1);
    check_val("f_c1_addr", bus.mmu_addr, 32'h8000_0000);
    check_val("f_c1_write", bus.mmu_write, 0);
    check_val("f_c1_grant", bus.grant_mem, 0);
    bus.mmu_rdata = 32'h1111_0001;
    step();
    check_val("f_c2_read", bus.mmu_read, 1);
    bus.mmu_rdata = 32'h2222_0002;
    step();
    check_val("f_c3_read", bus.mmu_read, 1);
    check_val("f_c3_addr", bus.mmu_addr, 32'h8000_0000);
    check_val("f_c3_bytemode", bus.mmu_bytemode, 0);
    bus.mmu_rdata = 32'h3333_0003;
    step();
    check_val("f_c4_if_ack", bus.if_ack, 1);
    check_val("f_c4_mem_ack", bus.mem_ack, 0);
    check_val("f_c4_rdata", bus.rdata, 32'h3333_0003);
    check_val("f_c4_read", bus.mmu_read, 0);
    check_val("f_c4_addr", bus.mmu_addr, 0);
    step();
    check_val("f_c5_no_regrant", bus.mmu_read, 0);
    check_val("f_c5_if_ack", bus.if_ack, 0);
    bus.if_req = 1'b0;

    // Contested store and fetch: store first, fetch granted the cycle after its ack
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h8040_0000;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_1000;
    step();
    check_val("s_c1_write", bus.mmu_write, 1);
    check_val("s_c1_read", bus.mmu_read, 0);
    check_val("s_c1_grant", bus.grant_mem, 1);
    check_val("s_c1_addr", bus.mmu_addr, 32'h8040_0000);
    check_val("s_c1_wdata", bus.mmu_wdata, 32'hDEAD_BEEF);
    step();
    step();
    check_val("s_c3_write", bus.mmu_write, 1);
    bus.mmu_rdata = 32'h5555_5555;
    step();
    check_val("s_c4_mem_ack", bus.mem_ack, 1);
    check_val("s_c4_if_ack", bus.if_ack, 0);
    check_val("s_c4_rdata", bus.rdata, 0);
    check_val("s_c4_grant", bus.grant_mem, 1);
    check_val("s_c4_write", bus.mmu_write, 0);
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    step();
    check_val("s_c5_grant", bus.grant_mem, 0);
    check_val("s_c5_read", bus.mmu_read, 0);
    step();
    check_val("s_c6_fetch_read", bus.mmu_read, 1);
    check_val("s_c6_fetch_addr", bus.mmu_addr, 32'h0000_1000);
    check_val("s_c6_fetch_wdata", bus.mmu_wdata, 0);
    check_val("s_c6_grant", bus.grant_mem, 0);
    bus.mmu_rdata = 32'h0BAD_F00D;
    step();
    step();
    step();
    check_val("s_c9_if_ack", bus.if_ack, 1);
    check_val("s_c9_rdata", bus.rdata, 32'h0BAD_F00D);
    bus.if_req = 1'b0;
    step();

    // Byte load
    bus.mem_req  = 1'b1;
    bus.mem_byte = 1'b1;
    bus.mem_addr = 32'hBFD0_03F8;
    for (int c = 1; c <= 3; c++) begin
      step();
      check_val($sformatf("b_c%0d_bytemode", c), bus.mmu_bytemode, 1);
      check_val($sformatf("b_c%0d_read", c), bus.mmu_read, 1);
      check_val($sformatf("b_c%0d_addr", c), bus.mmu_addr, 32'hBFD0_03F8);
      bus.mmu_rdata = 32'h0000_00A0 + 32'(c);
    end
    step();
    check_val("b_c4_mem_ack", bus.mem_ack, 1);
    check_val("b_c4_rdata", bus.rdata, 32'h0000_00A3);
    check_val("b_c4_bytemode", bus.mmu_bytemode, 0);
    bus.mem_req  = 1'b0;
    bus.mem_byte = 1'b0;
    step();

    // Reset in the second ACCESS cycle of a store aborts it without an ack
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0040;
    bus.mem_wdata = 32'h1234_5678;
    step();
    check_val("r_c1_write", bus.mmu_write, 1);
    step();
    check_val("r_c2_write", bus.mmu_write, 1);
    rst = 1'b1;
    step();
    check_val("r_c3_write", bus.mmu_write, 0);
    check_val("r_c3_grant", bus.grant_mem, 0);
    check_val("r_c3_wdata", bus.mmu_wdata, 0);
    rst = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check_val($sformatf("r_noack_%0d", c), bus.mem_ack, 0);
      check_val($sformatf("r_nowrite_%0d", c), bus.mmu_write, 0);
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_2000;
    step();
    check_val("r_idle_regrant", bus.mmu_read, 1);
    step();
    step();
    step();
    check_val("r_fetch_ack", bus.if_ack, 1);
    bus.if_req = 1'b0;
    step();

    // Both requests held high continuously
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h0000_0100;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0200;
    for (int c = 0; c < 200 && acks.size() < 10; c++) begin
      step();
      if (bus.mem_ack === 1'b1) acks.push_back(1);
      else if (bus.if_ack === 1'b1) acks.push_back(0);
    end
    check_val("c_ack_count", 32'(acks.size()), 32'd10);
    for (int i = 0; i < acks.size(); i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_src = (i % 5 == 4) ? 32'd0 : 32'd1;
`else
      exp_src = 32'd1;
`endif
      check_val($sformatf("c_ack_src_%0d", i), 32'(acks[i]), exp_src);
    end
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
